// File: rtl/riscv_noc_demux_buffered.sv
// Packet demux: routes each packet by the class field of its head flit into per-channel FIFOs.
// The route is held from head to last flit; multicast targets are pushed atomically.
module riscv_noc_demux_buffered #(
  parameter int          PLEN       = 64,
  parameter int          CHANNELS   = 2,
  parameter int          DEPTH      = 4,
  parameter int          CLASS_MSB  = 26,
  parameter int          CLASS_LSB  = 24,
  parameter logic [63:0] MAPPING    = 64'h0,
  parameter int          DEFAULT_CH = 0,
  parameter bit          MULTICAST  = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PLEN-1:0]                       in_flit,
  input  logic                                  in_last,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [CHANNELS*PLEN-1:0]              out_flit,
  output logic [CHANNELS-1:0]                   out_last,
  output logic [CHANNELS-1:0]                   out_valid,
  input  logic [CHANNELS-1:0]                   out_ready,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [2:0]          cls;
  logic [CHANNELS-1:0] raw_mask;
  logic [CHANNELS-1:0] head_mask;
  logic [CHANNELS-1:0] target;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] lock_mask;
  logic                lock_valid;
  logic                push;

  always_comb begin
    cls      = in_flit[CLASS_MSB:CLASS_LSB];
    raw_mask = CHANNELS'(MAPPING >> {cls, 3'b000});
    if (raw_mask == '0) raw_mask = CHANNELS'(1) << DEFAULT_CH;
    // Unicast keeps only the lowest set bit (two's-complement isolate).
    head_mask = MULTICAST ? raw_mask : (raw_mask & (~raw_mask + CHANNELS'(1)));
  end

  assign target   = lock_valid ? lock_mask : head_mask;
  // Only registered occupancy gates input, so out_ready never reaches in_ready.
  assign in_ready = !rst && ((target & full) == '0);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid <= 1'b0;
      lock_mask  <= '0;
    end else if (push) begin
      if (in_last) begin
        lock_valid <= 1'b0;
      end else if (!lock_valid) begin
        lock_valid <= 1'b1;
        lock_mask  <= head_mask;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PLEN:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   occ;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && target[c];
    assign do_pop  = (occ != '0) && out_ready[c];
    assign full[c] = (occ == OW'(DEPTH));

    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {in_last, in_flit};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)      occ <= occ + OW'(1);
        else if (!do_push && do_pop) occ <= occ - OW'(1);
      end
    end

    assign out_valid[c]               = (occ != '0);
    assign out_flit[c*PLEN +: PLEN]   = mem[rd_ptr][PLEN-1:0];
    assign out_last[c]                = mem[rd_ptr][PLEN];
    assign occupancy[c*OW +: OW]      = occ;
  end

endmodule

// File: tb/tb_riscv_noc_demux_buffered.sv
// Bench for riscv_noc_demux_buffered: routing vectors, corner sequences, and a random run
// against a queue-based reference model.
module tb_riscv_noc_demux_buffered;
  localparam int          PLEN  = 64;
  localparam int          DEPTH = 4;
  localparam int          OW    = 3;
  localparam logic [63:0] MAP1  = 64'h0000_00FE_0003_0201;
  localparam logic [63:0] MAP2  = 64'h0000_0000_0004_0006;

  logic              clk = 1'b0;
  logic              rst;
  logic [PLEN-1:0]   in_flit;
  logic              in_last, in_valid;
  logic              in_ready1, in_ready2;
  logic [2*PLEN-1:0] out_flit1;
  logic [1:0]        out_last1, out_valid1, out_ready1;
  logic [2*OW-1:0]   occupancy1;
  logic [3*PLEN-1:0] out_flit2;
  logic [2:0]        out_last2, out_valid2, out_ready2;
  logic [3*OW-1:0]   occupancy2;

  always #5 clk = ~clk;

  riscv_noc_demux_buffered #(.PLEN(PLEN), .CHANNELS(2), .DEPTH(DEPTH), .MAPPING(MAP1),
                             .DEFAULT_CH(0), .MULTICAST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready1), .out_flit(out_flit1), .out_last(out_last1), .out_valid(out_valid1),
    .out_ready(out_ready1), .occupancy(occupancy1));

  riscv_noc_demux_buffered #(.PLEN(PLEN), .CHANNELS(3), .DEPTH(DEPTH), .MAPPING(MAP2),
                             .DEFAULT_CH(1), .MULTICAST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready2), .out_flit(out_flit2), .out_last(out_last2), .out_valid(out_valid2),
    .out_ready(out_ready2), .occupancy(occupancy2));

  typedef logic [63:0] fq_t[$];
  typedef logic [64:0] eq_t[$];
  typedef struct { bit dut2; logic [2:0] cls; logic [2:0] exp; } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          acc   = 0;
  int          idx   = 0;
  fq_t         rx1[2];
  logic [63:0] fl[6];
  vec_t        vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkflit(input logic [2:0] cls, input int tag);
    logic [63:0] f;
    f = {32'hC0DE_0000 + 32'(tag), 32'(tag) * 32'h9E37_79B9};
    f[26:24] = cls;
    return f;
  endfunction

  // Sample transfers just before the edge, then return 1 time unit after it.
  task automatic tick();
    #1;
    if (in_valid && in_ready1) acc++;
    for (int c = 0; c < 2; c++)
      if (out_valid1[c] && out_ready1[c]) rx1[c].push_back(out_flit1[c*PLEN +: PLEN]);
    @(posedge clk);
    #1;
  endtask

  // Present fl[idx] until accepted; drop in_valid after the sixth flit.
  task automatic adv();
    tick();
    if (acc != idx) begin
      idx = acc;
      if (idx < 6) begin
        in_flit = fl[idx];
        in_last = (idx == 5);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    out_ready1 = '0; out_ready2 = '0;
    tick(); tick();
    rst = 1'b0; acc = 0;
    rx1[0].delete(); rx1[1].delete();
  endtask

  // Reference routing from the class rules: byte lookup, default on zero, multicast.
  function automatic logic [1:0] ref_mask(input logic [2:0] cls);
    logic [7:0] b;
    logic [1:0] m;
    b = 8'(MAP1 >> (8 * int'(cls)));
    m = b[1:0];
    if (m == 2'b00) m = 2'b01;
    return m;
  endfunction

  eq_t         mq[2];
  bit          m_locked;
  logic [1:0]  m_lock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_flit = '0; in_last = 1'b0; in_valid = 1'b0; rst = 1'b1;
    out_ready1 = '0; out_ready2 = '0;

    vecs[0]  = '{1'b0, 3'd0, 3'b001};
    vecs[1]  = '{1'b0, 3'd1, 3'b010};
    vecs[2]  = '{1'b0, 3'd2, 3'b011};
    vecs[3]  = '{1'b0, 3'd3, 3'b001};
    vecs[4]  = '{1'b0, 3'd4, 3'b010};
    vecs[5]  = '{1'b0, 3'd5, 3'b001};
    vecs[6]  = '{1'b0, 3'd6, 3'b001};
    vecs[7]  = '{1'b0, 3'd7, 3'b001};
    vecs[8]  = '{1'b1, 3'd0, 3'b010};
    vecs[9]  = '{1'b1, 3'd1, 3'b010};
    vecs[10] = '{1'b1, 3'd2, 3'b100};

    // Reset state: in_ready low while rst is high, even with a valid flit present.
    in_valid = 1'b1; in_last = 1'b1; in_flit = mkflit(3'd0, 1);
    #1;
    chk("rst_in_ready1", 64'(in_ready1), 64'd0);
    chk("rst_in_ready2", 64'(in_ready2), 64'd0);
    tick();
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_occupancy", 64'(occupancy1), 64'd0);
    do_reset();

    // Routing table: single-flit packets, one cycle latency, then drain.
    foreach (vecs[i]) begin
      in_flit = mkflit(vecs[i].cls, 100 + i); in_last = 1'b1; in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(vecs[i].dut2 ? in_ready2 : in_ready1), 64'd1);
      tick();
      in_valid = 1'b0;
      if (!vecs[i].dut2) begin
        chk($sformatf("vec%0d_valid", i), 64'(out_valid1), 64'(vecs[i].exp[1:0]));
        chk($sformatf("vec%0d_last", i), 64'(out_last1 & vecs[i].exp[1:0]), 64'(vecs[i].exp[1:0]));
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("vec%0d_occ%0d", i, c), 64'(occupancy1[c*OW +: OW]), 64'(vecs[i].exp[c]));
          if (vecs[i].exp[c])
            chk($sformatf("vec%0d_data%0d", i, c), out_flit1[c*PLEN +: PLEN], mkflit(vecs[i].cls, 100 + i));
        end
      end else begin
        chk($sformatf("vec%0d_valid", i), 64'(out_valid2), 64'(vecs[i].exp));
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("vec%0d_occ%0d", i, c), 64'(occupancy2[c*OW +: OW]), 64'(vecs[i].exp[c]));
          if (vecs[i].exp[c])
            chk($sformatf("vec%0d_data%0d", i, c), out_flit2[c*PLEN +: PLEN], mkflit(vecs[i].cls, 100 + i));
        end
      end
      out_ready1 = '1; out_ready2 = '1;
      tick(); tick(); tick(); tick(); tick();
      chk($sformatf("vec%0d_drain1", i), 64'(out_valid1), 64'd0);
      chk($sformatf("vec%0d_drain2", i), 64'(out_valid2), 64'd0);
      out_ready1 = '0; out_ready2 = '0;
    end

    // Route lock: later flits carry class 0 but follow the class-1 head.
    do_reset();
    fl[0] = mkflit(3'd1, 200); fl[1] = mkflit(3'd0, 201); fl[2] = mkflit(3'd0, 202);
    for (int k = 0; k < 3; k++) begin
      in_flit = fl[k]; in_last = (k == 2); in_valid = 1'b1;
      tick();
    end
    chk("lock_occ0", 64'(occupancy1[0 +: OW]), 64'd0);
    chk("lock_occ1", 64'(occupancy1[OW +: OW]), 64'd3);
    in_flit = mkflit(3'd0, 203); in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("unlock_occ0", 64'(occupancy1[0 +: OW]), 64'd1);
    chk("unlock_occ1", 64'(occupancy1[OW +: OW]), 64'd3);
    out_ready1 = 2'b11;
    for (int k = 0; k < 5; k++) tick();
    out_ready1 = 2'b00;
    chk("lock_rx1_size", 64'(rx1[1].size()), 64'd3);
    chk("lock_rx0_size", 64'(rx1[0].size()), 64'd1);
    if (rx1[1].size() == 3)
      for (int k = 0; k < 3; k++) chk($sformatf("lock_rx1_%0d", k), rx1[1][k], fl[k]);
    if (rx1[0].size() == 1) chk("unlock_rx0", rx1[0][0], mkflit(3'd0, 203));

    // Multicast with channel 1 stalled: four accepted, then blocked until it drains.
    do_reset();
    for (int k = 0; k < 6; k++) fl[k] = mkflit(3'd2, 300 + k);
    out_ready1 = 2'b01; idx = 0;
    in_flit = fl[0]; in_last = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) adv();
    chk("mc_accepted", 64'(acc), 64'd4);
    chk("mc_in_ready", 64'(in_ready1), 64'd0);
    chk("mc_occ0", 64'(occupancy1[0 +: OW]), 64'd0);
    chk("mc_occ1", 64'(occupancy1[OW +: OW]), 64'd4);
    out_ready1 = 2'b11;
    #1;
    chk("mc_full_pop_ready", 64'(in_ready1), 64'd0);
    for (int k = 0; k < 20; k++) adv();
    in_valid = 1'b0;
    chk("mc_accepted_all", 64'(acc), 64'd6);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("mc_rx%0d_size", c), 64'(rx1[c].size()), 64'd6);
      if (rx1[c].size() == 6)
        for (int k = 0; k < 6; k++) chk($sformatf("mc_rx%0d_%0d", c, k), rx1[c][k], fl[k]);
    end

    // Full FIFO popping in the same cycle still blocks input; the next cycle accepts.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_flit = mkflit(3'd0, 400 + k); in_last = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_flit = mkflit(3'd0, 404); out_ready1 = 2'b01;
    #1;
    chk("full_occ", 64'(occupancy1[0 +: OW]), 64'd4);
    chk("full_pop_in_ready", 64'(in_ready1), 64'd0);
    tick();
    chk("after_pop_occ", 64'(occupancy1[0 +: OW]), 64'd3);
    chk("after_pop_in_ready", 64'(in_ready1), 64'd1);
    tick();
    chk("push_pop_occ", 64'(occupancy1[0 +: OW]), 64'd3);
    chk("push_pop_head", out_flit1[0 +: PLEN], mkflit(3'd0, 402));
    in_valid = 1'b0; out_ready1 = 2'b00;

    // Reset mid-packet discards buffered flits and the lock.
    do_reset();
    in_flit = mkflit(3'd1, 500); in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_flit = mkflit(3'd0, 501);
    tick();
    chk("mid_occ1", 64'(occupancy1[OW +: OW]), 64'd2);
    rst = 1'b1;
    in_flit = mkflit(3'd0, 502);
    #1;
    chk("mid_rst_in_ready", 64'(in_ready1), 64'd0);
    tick();
    rst = 1'b0;
    chk("mid_valid", 64'(out_valid1), 64'd0);
    chk("mid_occupancy", 64'(occupancy1), 64'd0);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_next_valid", 64'(out_valid1), 64'd1);
    chk("mid_next_data", out_flit1[0 +: PLEN], mkflit(3'd0, 502));

    // Random traffic against the queue model.
    do_reset();
    out_ready2 = '1;
    m_locked = 1'b0; m_lock = '0;
    mq[0].delete(); mq[1].delete();
    begin
      int   pkt_left;
      bit   exp_rdy;
      bit   accepted;
      logic [1:0] tgt;
      pkt_left = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        if (!in_valid && $urandom_range(3) != 0) begin
          if (pkt_left == 0) pkt_left = $urandom_range(4, 1);
          in_flit  = {$urandom(), $urandom()};
          in_last  = (pkt_left == 1);
          in_valid = 1'b1;
        end
        out_ready1 = 2'($urandom_range(3));
        #1;
        tgt = m_locked ? m_lock : ref_mask(in_flit[26:24]);
        exp_rdy = 1'b1;
        for (int c = 0; c < 2; c++)
          if (tgt[c] && mq[c].size() >= DEPTH) exp_rdy = 1'b0;
        chk("rnd_in_ready", 64'(in_ready1), 64'(exp_rdy));
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("rnd_occ%0d", c), 64'(occupancy1[c*OW +: OW]), 64'(mq[c].size()));
          chk($sformatf("rnd_valid%0d", c), 64'(out_valid1[c]), 64'(mq[c].size() != 0));
          if (mq[c].size() != 0) begin
            chk($sformatf("rnd_flit%0d", c), out_flit1[c*PLEN +: PLEN], mq[c][0][63:0]);
            chk($sformatf("rnd_last%0d", c), 64'(out_last1[c]), 64'(mq[c][0][64]));
          end
        end
        for (int c = 0; c < 2; c++)
          if (mq[c].size() != 0 && out_ready1[c]) void'(mq[c].pop_front());
        accepted = in_valid && exp_rdy;
        if (accepted) begin
          for (int c = 0; c < 2; c++) if (tgt[c]) mq[c].push_back({in_last, in_flit});
          if (in_last) m_locked = 1'b0;
          else if (!m_locked) begin m_locked = 1'b1; m_lock = tgt; end
          pkt_left--;
        end
        @(posedge clk);
        #1;
        if (accepted) in_valid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_noc_demux_buffered.md
Name: riscv_noc_demux_buffered

Overview:
- Packet-level NoC demultiplexer with per-channel output FIFOs and registered outputs. Parametrised successor to the mesh-router class demux.
- Classifies each packet on its head flit and locks the route until the last flit. Supports multicast and a configurable default channel.
- Sits between a router output or NA ingress and CHANNELS downstream consumers. Decouples upstream ready from downstream ready: no combinational out_ready to in_ready path.

Parameters:
- PLEN, 64: flit width in bits.
- CHANNELS, 2: number of output channels, 1..8.
- DEPTH, 4: entries per output FIFO, power of two, >=2.
- CLASS_MSB, 26 / CLASS_LSB, 24: class field location in the head flit (3 bits).
- MAPPING, 64'h0: byte k is the channel mask for class k. Only the low CHANNELS bits of each byte are used.
- DEFAULT_CH, 0: channel used when the class mask is zero.
- MULTICAST, 1: 1 = all set mask bits receive the packet; 0 = only the lowest set bit.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_flit  in  PLEN  input flit
- in_last  in  1  last flit of packet
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out_flit  out  CHANNELS x PLEN  per-channel FIFO head flit
- out_last  out  CHANNELS  per-channel FIFO head last bit
- out_valid  out  CHANNELS  per-channel FIFO non-empty
- out_ready  in  CHANNELS  per-channel consumer ready
- occupancy  out  CHANNELS x clog2(DEPTH+1)  per-channel fill count

Behaviour:
- Reset (rst=1 at clk edge): all FIFOs empty, occupancy=0, out_valid=0, route lock cleared. in_ready must be 0 while rst=1.
- Reset mid-packet discards all buffered flits and the lock. The next flit accepted is treated as a head.
- Route computation, head flit only (lock clear):
  - mask = MAPPING[8*class +: CHANNELS].
  - If mask==0, mask = one-hot(DEFAULT_CH).
  - If MULTICAST=0, mask = lowest set bit of mask.
- Route lock: target = lock if lock valid, else the head mask.
  - On an accepted head with in_last=0: lock <= mask.
  - On an accepted flit with in_last=1: lock cleared.
  - A single-flit packet never sets the lock.
  - Lock updates only on an accepted transfer (in_valid & in_ready), never on valid alone.
- in_ready = !rst AND every target channel has occupancy < DEPTH.
  - It depends only on registered state and the current flit class, never on out_ready.
  - A full FIFO blocks input even if it pops that cycle.
- Transfer: in_valid & in_ready pushes {in_last, in_flit} into every target FIFO in the same cycle (atomic multicast). No partial delivery.
- Latency: a flit accepted at edge N appears at out_flit/out_valid after edge N. Minimum 1 cycle, no bypass.
- Output side:
  - out_valid[c] = occupancy[c] != 0.
  - Pop on out_valid[c] & out_ready[c].
  - out_flit/out_last are the FIFO head, stable while out_valid & !out_ready.
- Simultaneous push and pop on one channel: occupancy unchanged, order preserved. Pointers wrap modulo DEPTH.
- Channels drain independently. A stalled channel blocks input only when it is a target of the current packet.
- Upstream protocol: in_flit/in_last held stable while in_valid & !in_ready. in_valid is not withdrawn.
- occupancy range 0..DEPTH. It never exceeds DEPTH and never underflows.

Test Plan:
- Class routing: MAPPING=64'h0000_0000_0000_0201, send 1-flit class 0 then class 1 -> channel 0 then channel 1 each get one flit 1 cycle after accept. occupancy pulses to 1.
- Lock: class-1 packet of 3 flits whose later flits carry class bits =0 -> all 3 flits land on channel 1. Channel 0 stays empty. Lock clears after the last flit.
- Multicast/backpressure: MAPPING byte0=8'h03, MULTICAST=1, DEPTH=4, out_ready[1]=0, send 6 flits.
  - Required: 4 accepted into both FIFOs, then in_ready=0. Channel 0 drains 4 and still holds in_ready low.
  - Releasing out_ready[1] resumes input. Both channels receive identical 6-flit sequences.
- MULTICAST=0 with mask 8'h06 -> only channel 1 receives. Mask 0 with DEFAULT_CH=1 -> channel 1 receives.
- Full with simultaneous pop: occupancy=DEPTH, out_ready=1, in_valid=1 -> in_ready=0 that cycle. Next cycle occupancy=DEPTH-1, in_ready=1.
- Reset mid-packet: after 2 of 4 flits, pulse rst 1 cycle -> out_valid=0, occupancy=0. The next flit is routed by its own class field.
